// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, event kinds,
// mcause values, mtvec modes and the exception codes produced by the decoder.
// No logic; imported by trap_sequencer and trap_target_gen.
package trap_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KIND_EXC  = 2'd0,
        KIND_MRET = 2'd1,
        KIND_IRQ  = 2'd2
    } kind_t;

    localparam logic [31:0] MCAUSE_IRQ_MEXT = 32'h8000_000B;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    localparam logic [4:0] EXC_ILLEGAL = 5'd2;
    localparam logic [4:0] EXC_EBREAK  = 5'd3;
    localparam logic [4:0] EXC_ECALL_M = 5'd11;

    // Clear the two low bits (mode field of mtvec, misalignment of mepc).
    function automatic logic [31:0] align4(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/trap_target_gen.sv
// Redirect target for the trap sequencer: mepc for MRET, mtvec base for
// exceptions, base + 4*cause for interrupts in vectored mode.
// Purely combinational, zero latency; no flow control.
// Ports: kind (latched event kind), cause_lo (cause_q[4:0]), mtvec, mepc -> target.
module trap_target_gen
    import trap_sequencer_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [4:0]  cause_lo,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic [31:0] target
);

    logic [31:0] base;

    always_comb begin
        base   = align4(mtvec);
        target = base;
        case (kind_t'(kind))
            KIND_MRET: target = align4(mepc);
            KIND_IRQ: begin
                case (mtvec[1:0])
                    // Sum wraps naturally at 32 bits.
                    MTVEC_VECTORED: target = base + {25'd0, cause_lo, 2'b00};
                    MTVEC_DIRECT:   target = base;
                    default:        target = base;
                endcase
            end
            default: target = base;
        endcase
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap/MRET sequencer: accepts one event from DE, drains EX..WB, writes the
// trap CSRs, then redirects the PC. Accept->first IDLE is 4 cycles minimum.
// Holds the front end via trap_stall while busy; events outside IDLE are held, not lost.
// Ports: clk/rst (sync, active-high); DE event inputs; stage occupancy;
// mtvec/mepc CSR values; stall/flush/redirect controls; CSR write strobes; busy.
module trap_sequencer
    import trap_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        de_is_a_inst,
    input  logic [31:0] de_pc,
    input  logic        de_exception,
    input  logic [4:0]  de_exc_cause,
    input  logic        de_is_mret,
    input  logic        irq_pending,
    input  logic        irq_enable,
    input  logic        ex_is_a_inst,
    input  logic        m1_is_a_inst,
    input  logic        m2_is_a_inst,
    input  logic        wb_is_a_inst,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        trap_stall,
    output logic        trap_flush_ex,
    output logic        trap_flush_front,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        csr_trap_we,
    output logic        csr_mret_we,
    output logic [31:0] csr_mepc,
    output logic [31:0] csr_mcause,
    output logic        busy
);

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [31:0] pc_q;
    logic [31:0] cause_q, cause_d;
    logic        accept;
    logic        pipe_empty;
    logic [31:0] target;

    // Gating with rst keeps every output at 0 while reset is held in IDLE.
    assign accept = ~rst && (state_q == ST_IDLE) && de_is_a_inst &&
                    (de_exception || de_is_mret || (irq_pending && irq_enable));

    assign pipe_empty = ~(ex_is_a_inst | m1_is_a_inst | m2_is_a_inst | wb_is_a_inst);

    // Priority: exception > mret > interrupt.
    always_comb begin
        kind_d  = KIND_IRQ;
        cause_d = MCAUSE_IRQ_MEXT;
        if (de_exception) begin
            kind_d  = KIND_EXC;
            cause_d = {27'b0, de_exc_cause};
        end else if (de_is_mret) begin
            kind_d  = KIND_MRET;
            cause_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_EXC;
            pc_q    <= 32'd0;
            cause_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                kind_q  <= kind_d;
                pc_q    <= de_pc;
                cause_q <= cause_d;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        trap_stall       = 1'b0;
        trap_flush_ex    = 1'b0;
        trap_flush_front = 1'b0;
        redirect_valid   = 1'b0;
        csr_trap_we      = 1'b0;
        csr_mret_we      = 1'b0;
        csr_mepc         = 32'd0;
        csr_mcause       = 32'd0;
        busy             = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    trap_stall    = 1'b1;
                    trap_flush_ex = 1'b1;
                    state_d       = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Bubbles keep entering EX so the pipe only empties out.
                trap_stall    = 1'b1;
                trap_flush_ex = 1'b1;
                if (pipe_empty) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                trap_stall  = 1'b1;
                csr_trap_we = (kind_q != KIND_MRET);
                csr_mret_we = (kind_q == KIND_MRET);
                csr_mepc    = pc_q;
                csr_mcause  = cause_q;
                state_d     = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid   = 1'b1;
                trap_flush_front = 1'b1;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    trap_target_gen u_target_gen (
        .kind     (kind_q),
        .cause_lo (cause_q[4:0]),
        .mtvec    (mtvec),
        .mepc     (mepc),
        .target   (target)
    );

    assign redirect_pc = (state_q == ST_REDIRECT) ? target : 32'd0;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: table of single-event sequences,
// hand-written reset/interrupt-toggle sequences, and a random trace checked
// against a trace-level reference schedule.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        de_is_a_inst;
    logic [31:0] de_pc;
    logic        de_exception;
    logic [4:0]  de_exc_cause;
    logic        de_is_mret;
    logic        irq_pending;
    logic        irq_enable;
    logic        ex_is_a_inst, m1_is_a_inst, m2_is_a_inst, wb_is_a_inst;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        trap_stall, trap_flush_ex, trap_flush_front, redirect_valid;
    logic [31:0] redirect_pc;
    logic        csr_trap_we, csr_mret_we;
    logic [31:0] csr_mepc, csr_mcause;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trap_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .de_is_a_inst     (de_is_a_inst),
        .de_pc            (de_pc),
        .de_exception     (de_exception),
        .de_exc_cause     (de_exc_cause),
        .de_is_mret       (de_is_mret),
        .irq_pending      (irq_pending),
        .irq_enable       (irq_enable),
        .ex_is_a_inst     (ex_is_a_inst),
        .m1_is_a_inst     (m1_is_a_inst),
        .m2_is_a_inst     (m2_is_a_inst),
        .wb_is_a_inst     (wb_is_a_inst),
        .mtvec            (mtvec),
        .mepc             (mepc),
        .trap_stall       (trap_stall),
        .trap_flush_ex    (trap_flush_ex),
        .trap_flush_front (trap_flush_front),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .csr_trap_we      (csr_trap_we),
        .csr_mret_we      (csr_mret_we),
        .csr_mepc         (csr_mepc),
        .csr_mcause       (csr_mcause),
        .busy             (busy)
    );

    // {stall, flush_ex, flush_front, redirect_valid, trap_we, mret_we, busy}
    logic [6:0] flags;
    assign flags = {trap_stall, trap_flush_ex, trap_flush_front, redirect_valid,
                    csr_trap_we, csr_mret_we, busy};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_occ(input logic on, input int k);
        logic [3:0] occ;
        occ = on ? (4'b1000 >> (k % 4)) : 4'b0000;
        {ex_is_a_inst, m1_is_a_inst, m2_is_a_inst, wb_is_a_inst} = occ;
    endtask

    task automatic clear_events();
        de_is_a_inst = 1'b0;
        de_exception = 1'b0;
        de_is_mret   = 1'b0;
        irq_pending  = 1'b0;
        irq_enable   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_events();
        de_pc = 32'd0; de_exc_cause = 5'd0; mtvec = 32'd0; mepc = 32'd0;
        set_occ(1'b0, 0);
        tick();
        tick();
        @(negedge clk);
        check("reset flags", 32'(flags), 32'd0);
        check("reset redirect_pc", redirect_pc, 32'd0);
        check("reset csr_mepc", csr_mepc, 32'd0);
        check("reset csr_mcause", csr_mcause, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    // ---------------- table-driven single-event sequences ----------------
    typedef struct {
        logic        inst, exc;
        logic [4:0]  cause;
        logic        mret, irq_p, irq_en;
        logic [31:0] pc, tvec, epc;
        int          occ;       // DRAIN cycles with the pipe still occupied
        logic        exp_acc, exp_trap, exp_mret;
        logic [31:0] exp_mcause, exp_rpc;
    } vec_t;

    task automatic run_row(input int i, input vec_t v);
        de_is_a_inst = v.inst; de_exception = v.exc; de_exc_cause = v.cause;
        de_is_mret = v.mret; irq_pending = v.irq_p; irq_enable = v.irq_en;
        de_pc = v.pc; mtvec = v.tvec; mepc = v.epc;
        set_occ(v.occ > 0, 0);
        @(negedge clk);
        check($sformatf("row%0d accept stall", i), 32'(trap_stall), 32'(v.exp_acc));
        check($sformatf("row%0d accept flush_ex", i), 32'(trap_flush_ex), 32'(v.exp_acc));
        check($sformatf("row%0d accept busy", i), 32'(busy), 32'd0);
        tick();
        clear_events();
        if (!v.exp_acc) begin
            set_occ(1'b0, 0);
            @(negedge clk);
            check($sformatf("row%0d no-accept flags", i), 32'(flags), 32'd0);
            tick();
            return;
        end
        for (int k = 0; k < v.occ; k++) begin
            set_occ(1'b1, k);
            @(negedge clk);
            check($sformatf("row%0d drain%0d flags", i, k), 32'(flags), 32'b1100001);
            tick();
        end
        set_occ(1'b0, 0);
        @(negedge clk);
        check($sformatf("row%0d drain-exit flags", i), 32'(flags), 32'b1100001);
        tick();
        @(negedge clk);
        check($sformatf("row%0d commit flags", i), 32'(flags),
              32'({1'b1, 1'b0, 1'b0, 1'b0, v.exp_trap, v.exp_mret, 1'b1}));
        if (v.exp_trap) begin
            check($sformatf("row%0d csr_mepc", i), csr_mepc, v.pc);
            check($sformatf("row%0d csr_mcause", i), csr_mcause, v.exp_mcause);
        end
        tick();
        @(negedge clk);
        check($sformatf("row%0d redirect flags", i), 32'(flags), 32'b0011001);
        check($sformatf("row%0d redirect_pc", i), redirect_pc, v.exp_rpc);
        tick();
        @(negedge clk);
        check($sformatf("row%0d idle flags", i), 32'(flags), 32'd0);
        tick();
    endtask

    // ---------------- random trace with reference schedule ----------------
    localparam int N = 400;

    typedef struct {
        logic        inst, exc, mret, irq_p, irq_en;
        logic [4:0]  cause;
        logic [31:0] pc, tvec, epc;
        logic [3:0]  occ;
    } stim_t;

    typedef struct {
        logic [6:0]  flags;
        logic [31:0] rpc, mepc, mcause;
    } exp_t;

    stim_t st[N];
    exp_t  ex[N];

    function automatic logic [31:0] ref_target(input int kind, input logic [31:0] cause,
                                               input logic [31:0] tvec, input logic [31:0] epc);
        logic [31:0] base;
        base = (tvec / 4) * 4;
        if (kind == 1) return (epc / 4) * 4;
        if (kind == 2 && (tvec % 4) == 1) return base + (cause % 32) * 4;
        return base;
    endfunction

    task automatic build_random();
        logic [31:0] r;
        int t, d, kind;
        logic [31:0] cause, pc;
        for (int i = 0; i < N; i++) begin
            st[i].inst   = ($urandom_range(0, 99) < 60);
            st[i].exc    = ($urandom_range(0, 99) < 12);
            st[i].mret   = ($urandom_range(0, 99) < 12);
            st[i].irq_p  = ($urandom_range(0, 99) < 25);
            st[i].irq_en = ($urandom_range(0, 99) < 60);
            st[i].cause  = 5'($urandom_range(0, 31));
            st[i].pc     = $urandom;
            r            = $urandom;
            st[i].tvec   = {r[31:2], 2'($urandom_range(0, 3))};
            st[i].epc    = $urandom;
            st[i].occ    = {($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30),
                            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30)};
            ex[i] = '{flags: 7'd0, rpc: 32'd0, mepc: 32'd0, mcause: 32'd0};
        end
        // Walk the trace: an event seen while idle occupies the cycles
        // accept, drain..(first empty), commit, redirect.
        t = 0;
        while (t < N) begin
            if (st[t].inst && (st[t].exc || st[t].mret || (st[t].irq_p && st[t].irq_en))) begin
                if (st[t].exc)       begin kind = 0; cause = {27'd0, st[t].cause}; end
                else if (st[t].mret) begin kind = 1; cause = 32'd0; end
                else                 begin kind = 2; cause = 32'h8000_000B; end
                pc = st[t].pc;
                ex[t].flags = 7'b1100000;
                d = t + 1;
                while (d < N && st[d].occ != 4'd0) begin
                    ex[d].flags = 7'b1100001;
                    d++;
                end
                if (d < N) ex[d].flags = 7'b1100001;
                if (d + 1 < N) begin
                    ex[d+1].flags  = {4'b1000, (kind != 1), (kind == 1), 1'b1};
                    ex[d+1].mepc   = pc;
                    ex[d+1].mcause = cause;
                end
                if (d + 2 < N) begin
                    ex[d+2].flags = 7'b0011001;
                    ex[d+2].rpc   = ref_target(kind, cause, st[d+2].tvec, st[d+2].epc);
                end
                t = d + 3;
            end else begin
                t++;
            end
        end
    endtask

    vec_t tbl[10];

    initial begin
        rst = 1'b1;
        clear_events();
        de_pc = 32'd0; de_exc_cause = 5'd0; mtvec = 32'd0; mepc = 32'd0;
        set_occ(1'b0, 0);

        //           inst  exc   cause  mret  irq_p irq_en pc             mtvec          mepc           occ acc   trap  mret  mcause         rpc
        tbl[0] = '{1'b1, 1'b1, 5'd2,  1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_0800, 32'h0,         0, 1'b1, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0800};
        tbl[1] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_0801, 32'h0,         3, 1'b1, 1'b1, 1'b0, 32'h8000_000B, 32'h0000_082C};
        tbl[2] = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0800, 32'h0000_0200, 0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_0200};
        tbl[3] = '{1'b1, 1'b1, 5'd11, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0801, 32'h0000_0300, 2, 1'b1, 1'b1, 1'b0, 32'h0000_000B, 32'h0000_0800};
        tbl[4] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_0800, 32'h0,         0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        tbl[5] = '{1'b0, 1'b1, 5'd2,  1'b1, 1'b1, 1'b1, 32'h0000_0700, 32'h0000_0800, 32'h0,         0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        tbl[6] = '{1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_1003, 32'h0,         1, 1'b1, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_1000};
        tbl[7] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 32'h0000_0900, 32'h0000_0902, 32'h0,         0, 1'b1, 1'b1, 1'b0, 32'h8000_000B, 32'h0000_0900};
        tbl[8] = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0800, 32'h0000_0203, 1, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_0200};
        tbl[9] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFD, 32'h0,         0, 1'b1, 1'b1, 1'b0, 32'h8000_000B, 32'h0000_0028};

        do_reset();
        for (int i = 0; i < 10; i++) run_row(i, tbl[i]);

        // Reset during DRAIN aborts the sequence without CSR write or redirect.
        de_is_a_inst = 1'b1; de_exception = 1'b1; de_exc_cause = 5'd11;
        de_pc = 32'h0000_0088; mtvec = 32'h0000_0800;
        set_occ(1'b1, 0);
        @(negedge clk);
        check("rstdrain accept stall", 32'(trap_stall), 32'd1);
        tick();
        clear_events();
        set_occ(1'b1, 1);
        @(negedge clk);
        check("rstdrain in drain busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        de_is_a_inst = 1'b1; de_exception = 1'b1;
        @(negedge clk);
        check("rstdrain flags under reset", 32'(flags), 32'd0);
        check("rstdrain redirect_pc", redirect_pc, 32'd0);
        check("rstdrain csr_mepc", csr_mepc, 32'd0);
        tick();
        rst = 1'b0;
        clear_events();
        set_occ(1'b0, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rstdrain after%0d flags", k), 32'(flags), 32'd0);
            tick();
        end

        // irq_pending toggling during DRAIN does not disturb the sequence;
        // the held DE instruction is accepted again only after IDLE.
        de_is_a_inst = 1'b1; irq_pending = 1'b1; irq_enable = 1'b1;
        de_pc = 32'h0000_1234; mtvec = 32'h0000_0800;
        set_occ(1'b1, 0);
        @(negedge clk);
        check("irqtog accept stall", 32'(trap_stall), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            irq_pending = (k % 2 == 1);
            set_occ(k < 2, k);
            @(negedge clk);
            check($sformatf("irqtog drain%0d flags", k), 32'(flags), 32'b1100001);
            tick();
        end
        irq_pending = 1'b1;
        set_occ(1'b0, 0);
        @(negedge clk);
        check("irqtog commit flags", 32'(flags), 32'b1000101);
        check("irqtog csr_mcause", csr_mcause, 32'h8000_000B);
        check("irqtog csr_mepc", csr_mepc, 32'h0000_1234);
        tick();
        @(negedge clk);
        check("irqtog redirect flags", 32'(flags), 32'b0011001);
        check("irqtog redirect_pc", redirect_pc, 32'h0000_0800);
        tick();
        @(negedge clk);
        check("irqtog re-accept flags", 32'(flags), 32'b1100000);
        tick();

        // Random trace.
        do_reset();
        build_random();
        for (int t = 0; t < N; t++) begin
            de_is_a_inst = st[t].inst; de_exception = st[t].exc; de_exc_cause = st[t].cause;
            de_is_mret = st[t].mret; irq_pending = st[t].irq_p; irq_enable = st[t].irq_en;
            de_pc = st[t].pc; mtvec = st[t].tvec; mepc = st[t].epc;
            {ex_is_a_inst, m1_is_a_inst, m2_is_a_inst, wb_is_a_inst} = st[t].occ;
            @(negedge clk);
            check($sformatf("rand%0d flags", t), 32'(flags), 32'(ex[t].flags));
            check($sformatf("rand%0d redirect_pc", t), redirect_pc, ex[t].rpc);
            check($sformatf("rand%0d csr_mepc", t), csr_mepc, ex[t].mepc);
            check($sformatf("rand%0d csr_mcause", t), csr_mcause, ex[t].mcause);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 Ports SHALL be as follows; the block has one clock, and reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- de_is_a_inst  in  1  DE holds a valid instruction.
- de_pc  in  32  PC of the DE instruction.
- de_exception  in  1  DE instruction faults (illegal/ecall/ebreak).
- de_exc_cause  in  5  exception code for de_exception.
- de_is_mret  in  1  DE instruction is MRET.
- irq_pending  in  1  mip&mie nonzero, machine external.
- irq_enable  in  1  mstatus.MIE.
- ex_is_a_inst, m1_is_a_inst, m2_is_a_inst, wb_is_a_inst  in  1 each  stage occupancy.
- mtvec  in  32  trap vector CSR value.
- mepc  in  32  current mepc CSR value.
- trap_stall  out  1  stall PC/F2/DE; OR'ed with the hazard stalls.
- trap_flush_ex  out  1  inject bubble into EX.
- trap_flush_front  out  1  flush F2 and DE.
- redirect_valid  out  1  PC redirect strobe.
- redirect_pc  out  32  redirect target.
- csr_trap_we  out  1  write mepc/mcause, clear MIE.
- csr_mret_we  out  1  restore MIE.
- csr_mepc  out  32  value for mepc.
- csr_mcause  out  32  value for mcause.
- busy  out  1  state != IDLE.

Function
REQ-002 The FSM SHALL have four states: IDLE, DRAIN, COMMIT, REDIRECT.
REQ-003 In IDLE, an event SHALL be accepted when de_is_a_inst=1 and one of these holds: de_exception, de_is_mret, or irq_pending&irq_enable.
REQ-004 Event priority SHALL be exception > mret > interrupt, with a single event latched per acceptance.
REQ-005 On acceptance, the block SHALL latch pc_q=de_pc, kind_q and cause_q in the same cycle. Cause values:
- exception: {27'b0, de_exc_cause}.
- interrupt: 32'h8000_000B.
REQ-006 In the acceptance cycle, trap_stall=1 and trap_flush_ex=1 combinationally; the next state SHALL be DRAIN.
REQ-007 Acceptance SHALL be independent of hazard stalls; a DE instruction held by a load-use stall remains eligible.
REQ-008 In DRAIN, trap_stall=1 and trap_flush_ex=1 every cycle.
REQ-009 DRAIN SHALL exit to COMMIT in the first cycle in which ex/m1/m2/wb_is_a_inst are all 0.
REQ-010 If the pipe is already empty at acceptance, DRAIN SHALL last exactly one cycle.
REQ-011 In COMMIT, trap_stall=1 for one cycle, with either csr_trap_we=1 (exception/interrupt) or csr_mret_we=1 (mret). Next state is REDIRECT.
- csr_mepc=pc_q; csr_mcause=cause_q.
REQ-012 In REDIRECT, for one cycle: redirect_valid=1, trap_flush_front=1, trap_stall=0. Next state is IDLE.
REQ-013 redirect_pc SHALL be:
- mret: {mepc[31:2], 2'b00}, using mepc as sampled in REDIRECT.
- exception: {mtvec[31:2], 2'b00}.
- interrupt with mtvec[1:0]=2'b01: {mtvec[31:2], 2'b00} + (cause_q[4:0] << 2), 32-bit wrap.
- any other mode: base only.
REQ-014 Events SHALL be ignored outside IDLE; the front end is held and then flushed, so no event is lost.
REQ-015 An interrupt deasserting after acceptance SHALL NOT cancel the sequence.
REQ-016 Outside the above cases, all strobes SHALL be 0; busy=1 in DRAIN, COMMIT and REDIRECT.
REQ-017 The minimum sequence SHALL be 4 cycles from acceptance to the first IDLE cycle (accept, DRAIN, COMMIT, REDIRECT).

Reset
REQ-018 With rst=1 at a clock edge, the block SHALL enter IDLE, clear pc_q/cause_q/kind_q to 0, and drive all outputs to 0 (redirect_pc=0).
REQ-019 Reset mid-sequence SHALL abort it, with no CSR write and no redirect issued afterwards.

Structure
REQ-020 A shared package SHALL hold:
- the state enum;
- the kind enum (EXC, MRET, IRQ);
- MCAUSE_IRQ_MEXT=32'h8000_000B;
- MTVEC_DIRECT=2'b00 and MTVEC_VECTORED=2'b01;
- exception codes 2 (illegal), 3 (ebreak), 11 (ecall-M).
REQ-021 A combinational sub-module trap_target_gen SHALL compute redirect_pc from kind_q, cause_q, mtvec and mepc.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Illegal instruction (cause 2) at de_pc=32'h0000_0104, pipe empty, mtvec=32'h0000_0800 -> csr_trap_we at cycle+2 with mepc 0x104 and mcause 0x2; redirect_pc=0x800 at cycle+3.
- Interrupt with irq_enable=1, mtvec=32'h0000_0801, pipe occupied 3 more cycles -> DRAIN lasts 4 cycles; mcause 0x8000_000B; redirect_pc=0x82C.
- MRET with mepc=32'h0000_0200 -> csr_mret_we pulse with no csr_trap_we; redirect_pc=0x200.
- Exception, mret and interrupt asserted together -> exception taken only; one csr_trap_we pulse.
- rst asserted during DRAIN -> next cycle IDLE with all outputs 0, and no redirect ever observed.
- irq_pending toggled while in DRAIN -> sequence unaffected; a second acceptance occurs only after return to IDLE.
